// File: rtl/bitty_fetch_pkg.sv
// Shared types and constants for the bitty instruction sequencer.
// Optional watchdog is enabled by defining BITTY_FETCH_TIMEOUT_EN.
package bitty_fetch_pkg;

    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        HALTED
    } state_t;

endpackage

// File: rtl/bitty_fetch_if.sv
// run/done handshake between the fetch sequencer (master) and the bitty core (slave).
interface bitty_fetch_if;
    import bitty_fetch_pkg::*;

    logic               run;
    logic [INSTR_W-1:0] d_instr;
    logic               done;
    logic [INSTR_W-1:0] d_out;

    modport master (output run, output d_instr, input done, input d_out);
    modport slave  (input run, input d_instr, output done, output d_out);

endinterface

// File: rtl/bitty_fetch_ram.sv
// Program RAM: synchronous write, combinational read (a same-cycle read returns the old word).
module bitty_fetch_ram import bitty_fetch_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitty_fetch.sv
// Host-side instruction sequencer for the bitty run/done handshake.
// Define BITTY_FETCH_TIMEOUT_EN to add the WAIT-state watchdog and sticky err.
module bitty_fetch import bitty_fetch_pkg::*; #(
    parameter int unsigned        DEPTH     = 16,
    parameter int unsigned        AW        = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int unsigned        TMO_CYC   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    bitty_fetch_if.master      bus,
    output logic [INSTR_W-1:0] result,
    output logic               result_valid,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH) ||
        TMO_CYC == 0 || TMO_CYC > 255) begin : g_bad_cfg
        $error("bitty_fetch: invalid DEPTH/AW/TMO_CYC");
    end

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q;
    logic [INSTR_W-1:0] instr_q, result_q, ram_rdata;
    logic               rv_q, ram_we, is_halt, pc_last, issue_ok, tmo_hit;

    assign busy    = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);
    assign halted  = (state_q == HALTED);
    assign ram_we  = prog_we && !busy;
    assign is_halt = (ram_rdata == HALT_WORD);
    assign pc_last = (pc_q == AW'(DEPTH - 1));

    bitty_fetch_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (ram_rdata)
    );

    // run is asserted in ISSUE itself, so the RAM word is forwarded that cycle;
    // instr_q captures it at the same edge and holds it until the next issue.
    assign issue_ok     = (state_q == ISSUE) && !is_halt;
    assign bus.run      = issue_ok;
    assign bus.d_instr  = issue_ok ? ram_rdata : instr_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign pc           = pc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = is_halt ? HALTED : WAIT;
            WAIT: begin
                if (bus.done)     state_d = DRAIN;
                else if (tmo_hit) state_d = HALTED;
            end
            DRAIN:   if (!bus.done) state_d = pc_last ? HALTED : ISSUE;
            HALTED:  if (start) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= 1'b0;
            case (state_q)
                IDLE, HALTED: if (start) pc_q <= '0;
                ISSUE:        if (!is_halt) instr_q <= ram_rdata;
                WAIT: begin
                    if (bus.done) begin
                        result_q <= bus.d_out;
                        rv_q     <= 1'b1;
                    end
                end
                DRAIN:        if (!bus.done && !pc_last) pc_q <= pc_q + AW'(1);
                default: ;
            endcase
        end
    end

`ifdef BITTY_FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Counter restarts in ISSUE so every WAIT begins from zero.
    assign tmo_hit = (state_q == WAIT) && !bus.done && (tmo_cnt == 8'(TMO_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ISSUE)     tmo_cnt <= '0;
            else if (state_q == WAIT) tmo_cnt <= tmo_cnt + 8'd1;

            if (tmo_hit)                          err_q <= 1'b1;
            else if (state_q == HALTED && start)  err_q <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
